// File: rtl/dma_host_bus_master_if.sv
// Command/response handshake and DMA register-file pin bundle for dma_host_bus_master.
// The master modport is the initiator (DUT) view; slave is the command source / register-file side.
`timescale 1ns/1ps
interface dma_host_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_chan;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_count;
    logic [5:0]  cmd_mode;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        HLDA;
    logic        CS_N;
    logic        IOR_N;
    logic        IOW_N;
    logic [3:0]  A;
    logic [7:0]  DB_out;
    logic        DB_oe;
    logic [7:0]  DB_in;

    modport master (
        input  cmd_valid, cmd_op, cmd_chan, cmd_addr, cmd_count, cmd_mode, HLDA, DB_in,
        output cmd_ready, rsp_valid, rsp_data, busy, CS_N, IOR_N, IOW_N, A, DB_out, DB_oe
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_chan, cmd_addr, cmd_count, cmd_mode, HLDA, DB_in,
        input  cmd_ready, rsp_valid, rsp_data, busy, CS_N, IOR_N, IOW_N, A, DB_out, DB_oe
    );
endinterface

// File: rtl/dma_host_bus_master.sv
// Expands channel-level DMA commands into the 8-bit CS_N/IOR_N/IOW_N register cycles
// of the DMA register file, including byte-pointer flip-flop clears.
`timescale 1ns/1ps
module dma_host_bus_master #(
    parameter int unsigned IOW_PULSE = 2
) (
    input logic CLK,
    input logic RESET,
    dma_host_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_PROGRAM      = 2'd0,
        OP_READ_ADDR    = 2'd1,
        OP_READ_COUNT   = 2'd2,
        OP_MASTER_CLEAR = 2'd3
    } op_t;

    state_t      r_state;
    op_t         r_op;
    logic [1:0]  r_chan;
    logic [15:0] r_addr;
    logic [15:0] r_count;
    logic [5:0]  r_mode;
    logic [3:0]  r_step;
    logic [3:0]  r_strb_cnt;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;

    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_busy;
    logic        r_cs_n;
    logic        r_ior_n;
    logic        r_iow_n;
    logic [3:0]  r_a;
    logic [7:0]  r_db_out;
    logic        r_db_oe;

    logic [3:0]  w_reg_a;
    logic [7:0]  w_data;
    logic        w_rd;
    logic        w_last;
    logic [3:0]  w_chan_addr;
    logic [3:0]  w_chan_cnt;

    assign w_chan_addr = {1'b0, r_chan, 1'b0};
    assign w_chan_cnt  = {1'b0, r_chan, 1'b1};

    // Register address / data / direction for the current step of the latched command.
    always_comb begin
        w_reg_a = 4'hC;
        w_data  = '0;
        w_rd    = 1'b0;
        w_last  = 1'b0;
        case (r_op)
            OP_PROGRAM: begin
                w_last = (r_step == 4'd8);
                case (r_step)
                    4'd0: begin w_reg_a = 4'hA;        w_data = {6'b000001, r_chan}; end
                    4'd1, 4'd4: begin w_reg_a = 4'hC;  w_data = '0;                  end
                    4'd2: begin w_reg_a = w_chan_addr; w_data = r_addr[7:0];         end
                    4'd3: begin w_reg_a = w_chan_addr; w_data = r_addr[15:8];        end
                    4'd5: begin w_reg_a = w_chan_cnt;  w_data = r_count[7:0];        end
                    4'd6: begin w_reg_a = w_chan_cnt;  w_data = r_count[15:8];       end
                    4'd7: begin w_reg_a = 4'hB;        w_data = {r_mode, r_chan};    end
                    default: begin w_reg_a = 4'hA;     w_data = {6'b000000, r_chan}; end
                endcase
            end
            OP_READ_ADDR, OP_READ_COUNT: begin
                w_last = (r_step == 4'd2);
                if (r_step != 4'd0) begin
                    w_rd    = 1'b1;
                    w_reg_a = (r_op == OP_READ_COUNT) ? w_chan_cnt : w_chan_addr;
                end
            end
            default: begin
                w_last  = 1'b1;
                w_reg_a = 4'hD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_op        <= OP_PROGRAM;
            r_chan      <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_mode      <= '0;
            r_step      <= '0;
            r_strb_cnt  <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_ior_n     <= 1'b1;
            r_iow_n     <= 1'b1;
            r_a         <= '0;
            r_db_out    <= '0;
            r_db_oe     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_op        <= op_t'(bus.cmd_op);
                        r_chan      <= bus.cmd_chan;
                        r_addr      <= bus.cmd_addr;
                        r_count     <= bus.cmd_count;
                        r_mode      <= bus.cmd_mode;
                        r_step      <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.HLDA) begin
                        r_cs_n  <= 1'b0;
                        r_a     <= w_reg_a;
                        r_db_oe <= !w_rd;
                        if (!w_rd) r_db_out <= w_data;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_strb_cnt <= 4'(IOW_PULSE - 1);
                    if (w_rd) r_ior_n <= 1'b0;
                    else      r_iow_n <= 1'b0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_strb_cnt == 4'd0) begin
                        r_ior_n <= 1'b1;
                        r_iow_n <= 1'b1;
                        // Read data is captured on the same edge that releases IOR_N.
                        if (w_rd) begin
                            if (r_step == 4'd1) r_lo <= bus.DB_in;
                            else                r_hi <= bus.DB_in;
                        end
                        r_state <= S_HOLD;
                    end else begin
                        r_strb_cnt <= r_strb_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_cs_n  <= 1'b1;
                    r_db_oe <= 1'b0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_step  <= r_step + 4'd1;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= (r_op == OP_READ_ADDR || r_op == OP_READ_COUNT) ? {r_hi, r_lo} : '0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign bus.CS_N      = r_cs_n;
    assign bus.IOR_N     = r_ior_n;
    assign bus.IOW_N     = r_iow_n;
    assign bus.A         = r_a;
    assign bus.DB_out    = r_db_out;
    assign bus.DB_oe     = r_db_oe;

endmodule

// File: tb/tb_dma_host_bus_master.sv
// Directed bench for dma_host_bus_master: register-cycle sequences, readback, HLDA stall,
// mid-sequence reset and strobe widths for IOW_PULSE of 2, 1 and 15.
`timescale 1ns/1ps
module tb_dma_host_bus_master;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    dma_host_bus_master_if bus0();
    dma_host_bus_master_if bus1();
    dma_host_bus_master_if bus15();

    dma_host_bus_master #(.IOW_PULSE(2))  u_dut (.CLK(CLK), .RESET(RESET), .bus(bus0));
    dma_host_bus_master #(.IOW_PULSE(1))  u_p1  (.CLK(CLK), .RESET(RESET), .bus(bus1));
    dma_host_bus_master #(.IOW_PULSE(15)) u_p15 (.CLK(CLK), .RESET(RESET), .bus(bus15));

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    always @(posedge CLK) edge_cnt++;

    // Register-file read model: first read returns rd_lo, later reads rd_hi.
    int         rd_cnt = 0;
    int         rd_base = 0;
    logic [7:0] rd_lo = '0;
    logic [7:0] rd_hi = '0;
    assign bus0.DB_in  = (rd_cnt == rd_base) ? rd_lo : rd_hi;
    assign bus1.DB_in  = '0;
    assign bus15.DB_in = '0;
    assign bus1.HLDA   = 1'b0;
    assign bus15.HLDA  = 1'b0;

    // Bus monitor: {write, A, D} per strobe, strobe low width, CS_N coverage, responses.
    logic [12:0] mon_q[$];
    logic prev_iow0 = 1'b1, prev_ior0 = 1'b1;
    int   lowc0 = 0, width0 = 0, rsp_cnt = 0, cs_viol = 0;
    always @(negedge CLK) begin
        if (prev_iow0 && !bus0.IOW_N) mon_q.push_back({1'b1, bus0.A, bus0.DB_out});
        if (prev_ior0 && !bus0.IOR_N) mon_q.push_back({1'b0, bus0.A, 8'h00});
        if (!prev_ior0 && bus0.IOR_N) rd_cnt++;
        if ((!bus0.IOW_N || !bus0.IOR_N) && bus0.CS_N) cs_viol++;
        if (!bus0.IOW_N || !bus0.IOR_N) lowc0++;
        else if (lowc0 != 0) begin width0 = lowc0; lowc0 = 0; end
        if (bus0.rsp_valid === 1'b1) rsp_cnt++;
        prev_iow0 = bus0.IOW_N;
        prev_ior0 = bus0.IOR_N;
    end

    int lowc1 = 0, width1 = 0, rsp1_edge = 0;
    int lowc15 = 0, width15 = 0, rsp15_edge = 0;
    always @(negedge CLK) begin
        if (bus1.IOW_N === 1'b0) lowc1++;
        else if (lowc1 != 0) begin width1 = lowc1; lowc1 = 0; end
        if (bus1.rsp_valid === 1'b1 && rsp1_edge == 0) rsp1_edge = edge_cnt;
        if (bus15.IOW_N === 1'b0) lowc15++;
        else if (lowc15 != 0) begin width15 = lowc15; lowc15 = 0; end
        if (bus15.rsp_valid === 1'b1 && rsp15_edge == 0) rsp15_edge = edge_cnt;
    end

    logic [12:0] exp_prog [9] = '{13'h1A06, 13'h1C00, 13'h1434, 13'h1412, 13'h1C00,
                                  13'h15FF, 13'h1500, 13'h1B5A, 13'h1A02};
    logic [12:0] exp_rdc  [3] = '{13'h1C00, 13'h0700, 13'h0700};
    logic [12:0] exp_rda  [3] = '{13'h1C00, 13'h0000, 13'h0000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] chan, input logic [15:0] addr,
                         input logic [15:0] cnt, input logic [5:0] mode);
        bus0.cmd_op    = op;
        bus0.cmd_chan  = chan;
        bus0.cmd_addr  = addr;
        bus0.cmd_count = cnt;
        bus0.cmd_mode  = mode;
        bus0.cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        acc_edge = edge_cnt;
        bus0.cmd_valid = 1'b0;
        bus0.cmd_op    = ~op;
        bus0.cmd_chan  = ~chan;
        bus0.cmd_addr  = '1;
        bus0.cmd_count = '1;
        bus0.cmd_mode  = '1;
        check("cmd_ready_drop", 32'(bus0.cmd_ready), 32'd0);
        check("busy_rise", 32'(bus0.busy), 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        logic got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge CLK);
            if (bus0.rsp_valid === 1'b1) got = 1'b1;
        end
        check("rsp_seen", 32'(got), 32'd1);
        lat = edge_cnt - acc_edge;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base, cs_low, r0, acc2;
        logic found, both;
        bus0.cmd_valid = 1'b0; bus0.cmd_op = '0; bus0.cmd_chan = '0;
        bus0.cmd_addr = '0; bus0.cmd_count = '0; bus0.cmd_mode = '0; bus0.HLDA = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_chan = '0;
        bus1.cmd_addr = '0; bus1.cmd_count = '0; bus1.cmd_mode = '0;
        bus15.cmd_valid = 1'b0; bus15.cmd_op = '0; bus15.cmd_chan = '0;
        bus15.cmd_addr = '0; bus15.cmd_count = '0; bus15.cmd_mode = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_CS_N", 32'(bus0.CS_N), 32'd1);
        check("rst_IOR_N", 32'(bus0.IOR_N), 32'd1);
        check("rst_IOW_N", 32'(bus0.IOW_N), 32'd1);
        check("rst_DB_oe", 32'(bus0.DB_oe), 32'd0);
        check("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus0.rsp_data), 32'd0);
        check("rst_A", 32'(bus0.A), 32'd0);
        check("rst_DB_out", 32'(bus0.DB_out), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // PROGRAM ch2
        base = mon_q.size();
        issue(2'd0, 2'd2, 16'h1234, 16'h00FF, 6'h16);
        wait_rsp(lat);
        check("prog_latency", 32'(lat), 32'd55);
        check("prog_rsp_data", 32'(bus0.rsp_data), 32'd0);
        check("prog_busy_done", 32'(bus0.busy), 32'd0);
        check("prog_len", 32'(mon_q.size() - base), 32'd9);
        for (int i = 0; i < 9; i++)
            if (base + i < mon_q.size()) check($sformatf("prog_cyc%0d", i), 32'(mon_q[base + i]), 32'(exp_prog[i]));
        check("width_p2", 32'(width0), 32'd2);
        @(negedge CLK);
        check("prog_rsp_pulse", 32'(bus0.rsp_valid), 32'd0);

        // READ_COUNT ch3
        rd_lo = 8'hCD; rd_hi = 8'hAB; rd_base = rd_cnt;
        base = mon_q.size();
        issue(2'd2, 2'd3, 16'h0000, 16'h0000, 6'h00);
        wait_rsp(lat);
        check("rdc_latency", 32'(lat), 32'd19);
        check("rdc_rsp_data", 32'(bus0.rsp_data), 32'hABCD);
        check("rdc_len", 32'(mon_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < mon_q.size()) check($sformatf("rdc_cyc%0d", i), 32'(mon_q[base + i]), 32'(exp_rdc[i]));
        @(negedge CLK);
        check("rdc_rsp_pulse", 32'(bus0.rsp_valid), 32'd0);
        check("rdc_rsp_held", 32'(bus0.rsp_data), 32'hABCD);

        // MASTER_CLEAR accepted while HLDA is high
        bus0.HLDA = 1'b1;
        base = mon_q.size();
        issue(2'd3, 2'd0, 16'h0000, 16'h0000, 6'h00);
        cs_low = 0;
        repeat (6) begin
            @(negedge CLK);
            if (bus0.CS_N !== 1'b1) cs_low++;
        end
        check("hlda_cs_held", 32'(cs_low), 32'd0);
        check("hlda_busy", 32'(bus0.busy), 32'd1);
        bus0.HLDA = 1'b0;
        @(negedge CLK);
        check("hlda_cs_start", 32'(bus0.CS_N), 32'd0);
        check("hlda_A", 32'(bus0.A), 32'hD);
        check("hlda_DB_oe", 32'(bus0.DB_oe), 32'd1);
        wait_rsp(lat);
        check("mc_rsp_data", 32'(bus0.rsp_data), 32'd0);
        check("mc_len", 32'(mon_q.size() - base), 32'd1);
        if (base < mon_q.size()) check("mc_cyc0", 32'(mon_q[base]), 32'h1D00);

        // RESET during the 4th write of a PROGRAM
        issue(2'd0, 2'd1, 16'hBEEF, 16'h0010, 6'h2A);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLK);
            if (bus0.IOW_N === 1'b0 && bus0.A === 4'h2 && bus0.DB_out === 8'hBE) found = 1'b1;
        end
        check("rst4_found", 32'(found), 32'd1);
        r0 = rsp_cnt;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("rst4_CS_N", 32'(bus0.CS_N), 32'd1);
        check("rst4_IOW_N", 32'(bus0.IOW_N), 32'd1);
        check("rst4_IOR_N", 32'(bus0.IOR_N), 32'd1);
        check("rst4_DB_oe", 32'(bus0.DB_oe), 32'd0);
        check("rst4_busy", 32'(bus0.busy), 32'd0);
        check("rst4_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
        check("rst4_A", 32'(bus0.A), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (60) @(negedge CLK);
        check("rst4_no_rsp", 32'(rsp_cnt - r0), 32'd0);

        // READ_ADDR ch0 after the aborted PROGRAM
        rd_lo = 8'h5A; rd_hi = 8'hC3; rd_base = rd_cnt;
        base = mon_q.size();
        issue(2'd1, 2'd0, 16'h0000, 16'h0000, 6'h00);
        wait_rsp(lat);
        check("rda_latency", 32'(lat), 32'd19);
        check("rda_rsp_data", 32'(bus0.rsp_data), 32'hC35A);
        check("rda_len", 32'(mon_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < mon_q.size()) check($sformatf("rda_cyc%0d", i), 32'(mon_q[base + i]), 32'(exp_rda[i]));

        // Back-to-back MASTER_CLEAR in the first IDLE cycle
        check("b2b_ready", 32'(bus0.cmd_ready), 32'd1);
        issue(2'd3, 2'd0, 16'h0000, 16'h0000, 6'h00);
        wait_rsp(lat);
        check("b2b_mc_latency", 32'(lat), 32'd7);
        check("b2b_width_p2", 32'(width0), 32'd2);

        // Strobe width for IOW_PULSE = 1 and 15
        @(negedge CLK);
        bus1.cmd_op = 2'd3;  bus1.cmd_valid = 1'b1;
        bus15.cmd_op = 2'd3; bus15.cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        acc2 = edge_cnt;
        bus1.cmd_valid = 1'b0;
        bus15.cmd_valid = 1'b0;
        both = 1'b0;
        for (int k = 0; k < 100 && !both; k++) begin
            @(negedge CLK);
            if (rsp1_edge != 0 && rsp15_edge != 0) both = 1'b1;
        end
        check("pw_rsp_seen", 32'(both), 32'd1);
        check("pw1_width", 32'(width1), 32'd1);
        check("pw15_width", 32'(width15), 32'd15);
        check("pw1_latency", 32'(rsp1_edge - acc2), 32'd6);
        check("pw15_latency", 32'(rsp15_edge - acc2), 32'd20);

        check("cs_covers_strobe", 32'(cs_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
